mac_evt_unit: RTL and testbench
===============================

// Module: mac_evt_unit
// PURPOSE
// Downstream consumer of the MAC control block's per-core event vector (evt_o).
// - Counts event pulses per (core, event) pair.
// - Converts them into one level interrupt per core, with a latched event ID and an ack handshake.
// - Inserts a guaranteed low gap between interrupts, so cores never lose back-to-back job-end events.
// PARAMETERS
// N_CORES    2  number of cores, one irq/ack channel each
// N_EVT      2  events per core (matches REGFILE_N_EVT)
// CNT_WIDTH  4  width of each pending-event counter (saturating)
// GAP_CYC    2  cycles irq_o is held low after an ack, before re-assertion; GAP_CYC >= 1
// PORTS
// clk_i          in   1                clock
// rst_i          in   1                async reset, active-high
// clear_i        in   1                sync soft clear (driven by the slave clear_o)
// evt_i          in   N_CORES*N_EVT    event pulses; bit [c*N_EVT+e] = event e of core c
// ack_i          in   N_CORES          1-cycle ack per core, consumes the presented event
// irq_o          out  N_CORES          level interrupt per core
// irq_id_o       out  N_CORES*$clog2(N_EVT)  event index presented to core c; valid while irq_o[c]
// overflow_o     out  N_CORES          sticky: a counter of core c saturated and dropped an event
// BEHAVIOUR
// Reset
// - rst_i asynchronously sets all counters to 0, all FSMs to IDLE and the gap counters to 0.
// - Reset values: irq_o=0, irq_id_o=0, overflow_o=0.
// clear_i
// - Same effect as rst_i, but synchronous.
// - Has priority over evt_i and ack_i in the same cycle.
// - Takes effect mid-interrupt: irq_o drops on the next edge.
// Counters
// - There are N_CORES*N_EVT counters, each CNT_WIDTH bits wide.
// - Each cycle: cnt <= cnt + inc - dec.
//   - inc = evt_i bit.
//   - dec = 1 only for the counter being acked (see ASSERT below).
// - If inc and dec hit the same counter in one cycle, its value is unchanged.
// - Saturation: cnt == 2^CNT_WIDTH-1 with inc=1 and dec=0 -> cnt holds and overflow_o[c] <= 1.
//   - overflow_o[c] is sticky until rst_i or clear_i.
// - A counter never underflows, because dec is only generated when cnt > 0.
// Per-core FSM, states IDLE / ASSERT / GAP, all outputs registered
// - IDLE
//   - If any counter of core c is > 0 (registered value): go to ASSERT.
//   - On that transition: irq_o[c] <= 1 and irq_id_o[c] <= lowest-index nonzero event.
//   - Consequence: an evt_i pulse at edge t gives a counter of 1 at t+1 and irq_o high at t+2 (latency 2).
// - ASSERT
//   - irq_o[c]=1; irq_id_o[c] is stable for the whole assertion.
//   - On ack_i[c]=1: dec the counter at irq_id_o[c], irq_o[c] <= 0, load the gap counter with GAP_CYC-1, go to GAP.
//   - ack_i[c] in IDLE or GAP is ignored: no decrement, no state change.
// - GAP
//   - irq_o[c]=0; the gap counter decrements every cycle.
//   - When the gap counter is 0: go to IDLE, or directly to ASSERT if any counter of core c > 0.
//   - The direct re-entry also latches a new irq_id_o[c].
//   - Result: irq_o is low for exactly GAP_CYC cycles between consecutive interrupts.
// Other rules
// - Priority: within a core, the lowest event index is served first. Cores are fully independent.
// - evt_i pulses arriving in any state are always counted (subject only to saturation).
// TESTING
// 1. Reset and single event
//    - Apply rst_i, then pulse evt_i[0] once.
//    - Required: irq_o[0]=1 two cycles later, irq_id_o[0]=0.
//    - Ack -> irq_o[0]=0 for GAP_CYC=2 cycles, then stays 0; counter 0.
// 2. Back-to-back events
//    - Pulse evt_i[1] (core 0, evt 1) three times.
//    - Ack each as soon as it is presented.
//    - Required: exactly 3 assertions, each with id=1, separated by exactly 2 low cycles.
// 3. Priority
//    - Pulse evt_i[1] and evt_i[0] together.
//    - Required: first irq_id_o[0]=0; after ack and gap, second irq_id_o[0]=1.
// 4. Simultaneous inc/dec and saturation
//    - Hold evt_i[0] high while acking.
//      - Required: the counter is unchanged on the ack cycle.
//    - Then pulse 16 times with no ack (CNT_WIDTH=4).
//      - Required: counter=15 and overflow_o[0]=1.
//      - Then 15 acks drain the counter to 0.
// 5. Clear mid-operation
//    - Assert clear_i during ASSERT with ack_i high and evt_i high.
//    - Required: next cycle irq_o=0, overflow_o=0, all counters 0, no assertion afterwards.
// 6. Spurious acks and independent cores
//    - ack_i[1] pulsed in IDLE: no change.
//    - Core 1 events while core 0 is in GAP: core 1 irq timing is unaffected.

Source files
------------

// File: rtl/mac_evt_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_evt_unit
// Description : Counts per-core MAC event pulses and turns them into one level
//               interrupt per core, with an ack handshake and a low gap.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_evt_unit #(
    parameter int N_CORES   = 2,
    parameter int N_EVT     = 2,
    parameter int CNT_WIDTH = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic [N_CORES*N_EVT-1:0]           evt_i,
    input  logic [N_CORES-1:0]                 ack_i,
    output logic [N_CORES-1:0]                 irq_o,
    output logic [N_CORES*$clog2(N_EVT)-1:0]   irq_id_o,
    output logic [N_CORES-1:0]                 overflow_o
);

    localparam int c_id_w  = $clog2(N_EVT);
    localparam int c_gap_w = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [c_gap_w-1:0]   c_gap_one = c_gap_w'(1);
    localparam logic [c_gap_w-1:0]   c_gap_ld  = c_gap_w'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    genvar c;
    generate
        for (c = 0; c < N_CORES; c++) begin : g_core
            logic [CNT_WIDTH-1:0] r_cnt [N_EVT];
            state_t               r_state;
            logic                 r_irq;
            logic [c_id_w-1:0]    r_id;
            logic [c_gap_w-1:0]   r_gap;
            logic                 r_ovf;

            logic [N_EVT-1:0]     w_inc;
            logic [N_EVT-1:0]     w_dec;
            logic [N_EVT-1:0]     w_sat;
            logic                 w_ack;
            logic                 w_any;
            logic [c_id_w-1:0]    w_low_id;

            assign w_inc = evt_i[c*N_EVT +: N_EVT];
            assign w_ack = (r_state == ST_ASSERT) && ack_i[c];

            // Descending scan so the lowest nonzero index wins.
            always_comb begin
                w_any    = 1'b0;
                w_low_id = '0;
                w_dec    = '0;
                w_sat    = '0;
                for (int e = N_EVT - 1; e >= 0; e--) begin
                    w_sat[e] = (r_cnt[e] == c_cnt_max);
                    w_dec[e] = w_ack && (r_id == c_id_w'(e)) && (r_cnt[e] != '0);
                    if (r_cnt[e] != '0) begin
                        w_any    = 1'b1;
                        w_low_id = c_id_w'(e);
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int e = 0; e < N_EVT; e++) r_cnt[e] <= '0;
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_id    <= '0;
                    r_gap   <= '0;
                    r_ovf   <= 1'b0;
                end else if (clear_i) begin
                    for (int e = 0; e < N_EVT; e++) r_cnt[e] <= '0;
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_id    <= '0;
                    r_gap   <= '0;
                    r_ovf   <= 1'b0;
                end else begin
                    for (int e = 0; e < N_EVT; e++) begin
                        if (w_inc[e] && !w_dec[e] && !w_sat[e]) begin
                            r_cnt[e] <= r_cnt[e] + c_cnt_one;
                        end else if (w_dec[e] && !w_inc[e]) begin
                            r_cnt[e] <= r_cnt[e] - c_cnt_one;
                        end
                    end
                    if (|(w_inc & ~w_dec & w_sat)) begin
                        r_ovf <= 1'b1;
                    end

                    case (r_state)
                        ST_IDLE: begin
                            if (w_any) begin
                                r_state <= ST_ASSERT;
                                r_irq   <= 1'b1;
                                r_id    <= w_low_id;
                            end
                        end
                        ST_ASSERT: begin
                            if (ack_i[c]) begin
                                r_state <= ST_GAP;
                                r_irq   <= 1'b0;
                                r_gap   <= c_gap_ld;
                            end
                        end
                        ST_GAP: begin
                            // Counters already reflect the ack decrement here.
                            if (r_gap == '0) begin
                                if (w_any) begin
                                    r_state <= ST_ASSERT;
                                    r_irq   <= 1'b1;
                                    r_id    <= w_low_id;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end else begin
                                r_gap <= r_gap - c_gap_one;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_irq   <= 1'b0;
                        end
                    endcase
                end
            end

            assign irq_o[c]                     = r_irq;
            assign irq_id_o[c*c_id_w +: c_id_w] = r_id;
            assign overflow_o[c]                = r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_evt_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_evt_unit
// Description : Directed self-checking bench for mac_evt_unit (2 cores, 2 events).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_evt_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] evt;
    logic [1:0] ack;
    logic [1:0] irq;
    logic [1:0] irq_id;
    logic [1:0] ovf;

    int errors = 0;
    int checks = 0;
    int n;

    mac_evt_unit #(
        .N_CORES  (2),
        .N_EVT    (2),
        .CNT_WIDTH(4),
        .GAP_CYC  (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (clear),
        .evt_i     (evt),
        .ack_i     (ack),
        .irq_o     (irq),
        .irq_id_o  (irq_id),
        .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until irq[c] is high; returns budget if it never rises.
    task automatic wait_irq(input int c, input int budget, output int cnt);
        cnt = 0;
        while (irq[c] !== 1'b1 && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clear = 1'b0; evt = '0; ack = '0;
        tick(); tick();
        chk("rst_irq", irq, 2'b00);
        chk("rst_id", irq_id, 2'b00);
        chk("rst_ovf", ovf, 2'b00);
        rst = 1'b0;
        tick();

        // 1. single event, latency 2, then gap and quiet
        evt = 4'b0001; tick(); evt = '0;
        chk("t1_lat1", irq[0], 1'b0);
        tick();
        chk("t1_irq", irq[0], 1'b1);
        chk("t1_id", irq_id[0], 1'b0);
        ack = 2'b01; tick(); ack = '0;
        chk("t1_ackdrop", irq[0], 1'b0);
        wait_irq(0, 6, n);
        chk("t1_quiet", n, 6);

        // 2. three back-to-back events on core 0 event 1
        evt = 4'b0010; tick(); tick(); tick(); evt = '0;
        chk("t2_irq", irq[0], 1'b1);
        chk("t2_id", irq_id[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_irq(0, 10, n);
                chk("t2_gap", n, 2);
                chk("t2_idk", irq_id[0], 1'b1);
            end
            ack = 2'b01; tick(); ack = '0;
        end
        wait_irq(0, 8, n);
        chk("t2_noextra", n, 8);

        // 3. priority: event 0 served before event 1
        evt = 4'b0011; tick(); evt = '0; tick();
        chk("t3_irq", irq[0], 1'b1);
        chk("t3_id0", irq_id[0], 1'b0);
        ack = 2'b01; tick(); ack = '0;
        wait_irq(0, 10, n);
        chk("t3_gap", n, 2);
        chk("t3_id1", irq_id[0], 1'b1);
        ack = 2'b01; tick(); ack = '0;
        wait_irq(0, 6, n);
        chk("t3_quiet", n, 6);

        // 4a. inc and dec on the same counter leave it at 1
        evt = 4'b0001; tick(); evt = '0; tick();
        chk("t4_irq", irq[0], 1'b1);
        evt = 4'b0001; ack = 2'b01; tick(); evt = '0; ack = '0;
        wait_irq(0, 10, n);
        chk("t4_reassert", n, 2);
        chk("t4_id", irq_id[0], 1'b0);
        ack = 2'b01; tick(); ack = '0;
        wait_irq(0, 6, n);
        chk("t4_empty", n, 6);

        // 4b. saturation at 15, then drain with exactly 15 acks
        evt = 4'b0001;
        for (int k = 0; k < 15; k++) tick();
        chk("t4_ovf_pre", ovf[0], 1'b0);
        tick(); evt = '0;
        chk("t4_ovf", ovf[0], 1'b1);
        for (int k = 0; k < 15; k++) begin
            wait_irq(0, 10, n);
            chk("t4_drain", irq[0], 1'b1);
            ack = 2'b01; tick(); ack = '0;
        end
        wait_irq(0, 8, n);
        chk("t4_drained", n, 8);
        chk("t4_ovf_sticky", ovf[0], 1'b1);

        // 5. clear while asserting, with ack and evt in the same cycle
        evt = 4'b0101; tick(); evt = '0; tick();
        chk("t5_irq", irq, 2'b11);
        clear = 1'b1; ack = 2'b01; evt = 4'b0101; tick();
        clear = 1'b0; ack = '0; evt = '0;
        chk("t5_irq_clr", irq, 2'b00);
        chk("t5_ovf_clr", ovf, 2'b00);
        chk("t5_id_clr", irq_id, 2'b00);
        wait_irq(0, 8, n);
        chk("t5_quiet0", n, 8);
        wait_irq(1, 6, n);
        chk("t5_quiet1", n, 6);

        // 6. spurious ack on idle core 1, then core 1 while core 0 in GAP
        ack = 2'b10; tick(); ack = '0;
        chk("t6_spur", irq, 2'b00);
        wait_irq(1, 6, n);
        chk("t6_spur_quiet", n, 6);
        evt = 4'b0001; tick(); evt = '0; tick();
        chk("t6_c0irq", irq[0], 1'b1);
        ack = 2'b01; tick(); ack = '0;
        evt = 4'b1000; tick(); evt = '0;
        chk("t6_c1lat1", irq[1], 1'b0);
        tick();
        chk("t6_c1irq", irq[1], 1'b1);
        chk("t6_c1id", irq_id[1], 1'b1);
        chk("t6_c0low", irq[0], 1'b0);
        ack = 2'b10; tick(); ack = '0;
        chk("t6_c1ack", irq, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
